// File: rtl/mips_intr_ctrl_pkg.sv
// Shared types and defaults for the MIPS interrupt sequencer: cause encodings,
// sequencer states, default handler vectors and the cause-selection helper.
package mips_intr_ctrl_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_INT  = 2'b01,
    CAUSE_NMI  = 2'b10
  } cause_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_FLUSH   = 3'd2,
    ST_VECTOR  = 3'd3,
    ST_HANDLER = 3'd4,
    ST_RETURN  = 3'd5
  } state_e;

  localparam logic [31:0] DEF_INT_VECTOR = 32'h0000_0080;
  localparam logic [31:0] DEF_NMI_VECTOR = 32'h0000_0100;
  localparam int          DEF_DRAIN_CYC  = 3;

  // NMI always outranks INT; with neither present the current cause is kept.
  function automatic cause_e pick_cause(input logic take_nmi, input logic take_int,
                                        input cause_e cur);
    cause_e res;
    if (take_nmi) begin
      res = CAUSE_NMI;
    end else if (take_int) begin
      res = CAUSE_INT;
    end else begin
      res = cur;
    end
    return res;
  endfunction

endpackage

// File: rtl/mips_intr_ctrl_if.sv
// Pipeline-side connection of the interrupt sequencer: request inputs from the
// CPU and the stall/flush/redirect controls returned to it.
interface mips_intr_ctrl_if
  import mips_intr_ctrl_pkg::*;
#(
  parameter int PC_W = 32
);
  logic            int_req;
  logic            nmi;
  logic            int_flag;
  logic [PC_W-1:0] restart_pc;
  logic            drain_ok;
  logic            eret;
  logic            stall_req;
  logic            flush;
  logic            pc_load;
  logic [PC_W-1:0] pc_target;
  logic [PC_W-1:0] epc;
  cause_e          cause;
  logic            in_handler;

  modport master (
    output int_req, nmi, int_flag, restart_pc, drain_ok, eret,
    input  stall_req, flush, pc_load, pc_target, epc, cause, in_handler
  );

  modport slave (
    input  int_req, nmi, int_flag, restart_pc, drain_ok, eret,
    output stall_req, flush, pc_load, pc_target, epc, cause, in_handler
  );
endinterface

// File: rtl/mips_intr_ctrl_edge_latch.sv
// Rising-edge detector with a sticky pending flag; a new edge beats a
// simultaneous clear so no NMI is ever lost.
module mips_intr_ctrl_edge_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic nmi,
  input  logic clr,
  output logic pend
);
  logic nmi_prev_r;
  logic pend_r;

  // Previous-level register starts low, so a line already high at reset release is an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_prev_r <= 1'b0;
      pend_r     <= 1'b0;
    end else begin
      nmi_prev_r <= nmi;
      if (nmi && !nmi_prev_r) begin
        pend_r <= 1'b1;
      end else if (clr) begin
        pend_r <= 1'b0;
      end
    end
  end

  assign pend = pend_r;
endmodule

// File: rtl/mips_intr_ctrl.sv
// Interrupt sequencer: drains and flushes the pipeline, saves the restart PC,
// vectors to the INT/NMI handler and returns to the saved PC on ERET.
module mips_intr_ctrl
  import mips_intr_ctrl_pkg::*;
#(
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] INT_VECTOR = DEF_INT_VECTOR,
  parameter logic [PC_W-1:0] NMI_VECTOR = DEF_NMI_VECTOR,
  parameter int              DRAIN_CYC  = DEF_DRAIN_CYC
) (
  input logic             clk,
  input logic             rst_n,
  mips_intr_ctrl_if.slave bus
);
  localparam int             CNT_W      = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_e           state_r;
  cause_e           cause_r;
  logic [CNT_W-1:0] cnt_r;
  logic [PC_W-1:0]  epc_r;
  logic [PC_W-1:0]  pc_target_r;
  logic             stall_r;
  logic             flush_r;
  logic             pc_load_r;
  logic             in_handler_r;

  logic             nmi_pend_s;
  logic             nmi_clr_s;
  logic             take_int_s;
  logic             drain_done_s;
  cause_e           cause_eff_s;

  mips_intr_ctrl_edge_latch u_nmi_latch (
    .clk   (clk),
    .rst_n (rst_n),
    .nmi   (bus.nmi),
    .clr   (nmi_clr_s),
    .pend  (nmi_pend_s)
  );

  // Request qualification, drain completion and the NMI upgrade seen while draining.
  always_comb begin
    take_int_s   = bus.int_req & bus.int_flag & ~in_handler_r;
    drain_done_s = (cnt_r >= DRAIN_LAST) & bus.drain_ok;
    cause_eff_s  = pick_cause(nmi_pend_s, 1'b0, cause_r);
    nmi_clr_s    = (state_r == ST_DRAIN) & drain_done_s & (cause_eff_s == CAUSE_NMI);
  end

  // Sequencer; every output register is loaded with the decode of the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cause_r      <= CAUSE_NONE;
      cnt_r        <= {CNT_W{1'b0}};
      epc_r        <= {PC_W{1'b0}};
      pc_target_r  <= {PC_W{1'b0}};
      stall_r      <= 1'b0;
      flush_r      <= 1'b0;
      pc_load_r    <= 1'b0;
      in_handler_r <= 1'b0;
    end else begin
      stall_r     <= 1'b0;
      flush_r     <= 1'b0;
      pc_load_r   <= 1'b0;
      pc_target_r <= {PC_W{1'b0}};
      case (state_r)
        ST_IDLE: begin
          if (nmi_pend_s || take_int_s) begin
            state_r <= ST_DRAIN;
            cause_r <= pick_cause(nmi_pend_s, take_int_s, cause_r);
            cnt_r   <= {CNT_W{1'b0}};
            stall_r <= 1'b1;
          end
        end
        ST_DRAIN: begin
          cause_r <= cause_eff_s;
          stall_r <= 1'b1;
          if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
          if (drain_done_s) begin
            state_r <= ST_FLUSH;
            flush_r <= 1'b1;
          end
        end
        ST_FLUSH: begin
          epc_r       <= bus.restart_pc;
          pc_load_r   <= 1'b1;
          pc_target_r <= (cause_r == CAUSE_NMI) ? NMI_VECTOR : INT_VECTOR;
          state_r     <= ST_VECTOR;
        end
        ST_VECTOR: begin
          in_handler_r <= 1'b1;
          state_r      <= ST_HANDLER;
        end
        ST_HANDLER: begin
          // A single EPC means nested NMIs only stay pending until ERET.
          if (bus.eret) begin
            state_r     <= ST_RETURN;
            pc_load_r   <= 1'b1;
            pc_target_r <= epc_r;
            flush_r     <= 1'b1;
          end
        end
        ST_RETURN: begin
          in_handler_r <= 1'b0;
          if (nmi_pend_s) begin
            state_r <= ST_DRAIN;
            cause_r <= CAUSE_NMI;
            cnt_r   <= {CNT_W{1'b0}};
            stall_r <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            cause_r <= CAUSE_NONE;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          cause_r      <= CAUSE_NONE;
          in_handler_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stall_req  = stall_r;
  assign bus.flush      = flush_r;
  assign bus.pc_load    = pc_load_r;
  assign bus.pc_target  = pc_target_r;
  assign bus.epc        = epc_r;
  assign bus.cause      = cause_r;
  assign bus.in_handler = in_handler_r;
endmodule

// File: tb/tb_mips_intr_ctrl.sv
// Directed bench for the interrupt sequencer: hand-computed cycle-exact
// expectations for INT, NMI, masking, drain hold, nested NMI and reset.
module tb_mips_intr_ctrl;
  import mips_intr_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mips_intr_ctrl_if #(.PC_W(32)) bus ();

  mips_intr_ctrl #(
    .PC_W       (32),
    .INT_VECTOR (32'h0000_0080),
    .NMI_VECTOR (32'h0000_0100),
    .DRAIN_CYC  (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pc_load(input string tag, input int budget);
    int n;
    n = 0;
    while (!bus.pc_load && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_pc_load_seen"}, 32'(bus.pc_load), 32'd1);
  endtask

  // Called in the VECTOR cycle; leaves the bench one cycle after RETURN.
  task automatic finish_handler(input string tag, input logic [31:0] exp_epc);
    tick();
    check({tag, "_in_handler"}, 32'(bus.in_handler), 32'd1);
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    check({tag, "_ret_pc_load"}, 32'(bus.pc_load), 32'd1);
    check({tag, "_ret_target"}, bus.pc_target, exp_epc);
    check({tag, "_ret_flush"}, 32'(bus.flush), 32'd1);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, 32'(bus.stall_req), 32'd0);
    check({tag, "_flush"}, 32'(bus.flush), 32'd0);
    check({tag, "_pc_load"}, 32'(bus.pc_load), 32'd0);
    check({tag, "_target"}, bus.pc_target, 32'd0);
    check({tag, "_epc"}, bus.epc, 32'd0);
    check({tag, "_cause"}, 32'(bus.cause), 32'd0);
    check({tag, "_in_handler"}, 32'(bus.in_handler), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int drain_n;
    int cnt;
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.int_req   = 1'b0;
    bus.nmi       = 1'b0;
    bus.int_flag  = 1'b0;
    bus.restart_pc = 32'd0;
    bus.drain_ok  = 1'b1;
    bus.eret      = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: plain INT
    bus.restart_pc = 32'h40;
    bus.int_flag   = 1'b1;
    bus.int_req    = 1'b1;
    tick();
    check("t1_cause_drain", 32'(bus.cause), 32'd1);
    bus.int_req = 1'b0;
    drain_n = (bus.stall_req && !bus.flush) ? 1 : 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (bus.stall_req && !bus.flush) drain_n++;
    end
    check("t1_drain_cycles", 32'(drain_n), 32'd3);
    tick();
    check("t1_flush", 32'(bus.flush), 32'd1);
    check("t1_flush_stall", 32'(bus.stall_req), 32'd1);
    tick();
    check("t1_pc_load", 32'(bus.pc_load), 32'd1);
    check("t1_target", bus.pc_target, 32'h80);
    check("t1_epc", bus.epc, 32'h40);
    check("t1_cause", 32'(bus.cause), 32'd1);
    check("t1_flush_once", 32'(bus.flush), 32'd0);
    finish_handler("t1", 32'h40);
    check("t1_idle_cause", 32'(bus.cause), 32'd0);
    check("t1_idle_in_handler", 32'(bus.in_handler), 32'd0);
    check("t1_epc_hold", bus.epc, 32'h40);
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    check("eret_idle_ignored", 32'(bus.pc_load), 32'd0);

    // 2: INT masked by INT_FLAG, then enabled
    bus.int_flag = 1'b0;
    bus.int_req  = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.stall_req) cnt++;
    end
    check("t2_masked_stalls", 32'(cnt), 32'd0);
    bus.restart_pc = 32'h48;
    bus.int_flag   = 1'b1;
    tick();
    check("t2_start", 32'(bus.stall_req), 32'd1);
    bus.int_req = 1'b0;
    wait_pc_load("t2", 10);
    check("t2_target", bus.pc_target, 32'h80);
    finish_handler("t2", 32'h48);

    // 3: INT and NMI edge together; INT re-taken after ERET
    bus.restart_pc = 32'h44;
    bus.int_req    = 1'b1;
    bus.nmi        = 1'b1;
    tick();
    tick();
    check("t3_upgrade", 32'(bus.cause), 32'd2);
    bus.nmi = 1'b0;
    wait_pc_load("t3", 10);
    check("t3_cause", 32'(bus.cause), 32'd2);
    check("t3_target", bus.pc_target, 32'h100);
    finish_handler("t3", 32'h44);
    check("t3_idle_after", 32'(bus.stall_req), 32'd0);
    tick();
    check("t3_int_again_stall", 32'(bus.stall_req), 32'd1);
    check("t3_int_again_cause", 32'(bus.cause), 32'd1);
    bus.int_req = 1'b0;
    wait_pc_load("t3b", 10);
    check("t3b_target", bus.pc_target, 32'h80);
    finish_handler("t3b", 32'h44);

    // 4: DRAIN_OK held low
    bus.restart_pc = 32'h4C;
    bus.drain_ok   = 1'b0;
    bus.int_req    = 1'b1;
    tick();
    bus.int_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!bus.stall_req || bus.flush) cnt++;
    end
    check("t4_hold_bad", 32'(cnt), 32'd0);
    bus.drain_ok = 1'b1;
    tick();
    check("t4_flush", 32'(bus.flush), 32'd1);
    tick();
    check("t4_target", bus.pc_target, 32'h80);
    check("t4_epc", bus.epc, 32'h4C);
    finish_handler("t4", 32'h4C);

    // 5: NMI edge inside handler is held until ERET
    bus.restart_pc = 32'h50;
    bus.int_req    = 1'b1;
    tick();
    bus.int_req = 1'b0;
    wait_pc_load("t5", 10);
    check("t5_int_target", bus.pc_target, 32'h80);
    tick();
    bus.nmi = 1'b1;
    tick();
    bus.nmi = 1'b0;
    tick();
    check("t5_not_taken_pcl", 32'(bus.pc_load), 32'd0);
    check("t5_not_taken_stall", 32'(bus.stall_req), 32'd0);
    check("t5_still_handler", 32'(bus.in_handler), 32'd1);
    bus.restart_pc = 32'h60;
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    check("t5_ret_pc_load", 32'(bus.pc_load), 32'd1);
    check("t5_ret_target", bus.pc_target, 32'h50);
    tick();
    check("t5_nmi_drain", 32'(bus.stall_req), 32'd1);
    check("t5_nmi_cause", 32'(bus.cause), 32'd2);
    wait_pc_load("t5n", 10);
    check("t5_nmi_target", bus.pc_target, 32'h100);
    check("t5_nmi_epc", bus.epc, 32'h60);
    finish_handler("t5n", 32'h60);
    check("t5_idle_cause", 32'(bus.cause), 32'd0);

    // 6: reset during DRAIN
    bus.restart_pc = 32'h70;
    bus.int_req    = 1'b1;
    tick();
    tick();
    check("t6_draining", 32'(bus.stall_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t6_retake_stall", 32'(bus.stall_req), 32'd1);
    check("t6_retake_cause", 32'(bus.cause), 32'd1);
    bus.int_req = 1'b0;
    wait_pc_load("t6", 10);
    check("t6_target", bus.pc_target, 32'h80);
    check("t6_epc", bus.epc, 32'h70);
    finish_handler("t6", 32'h70);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
